// File: rtl/mux5_arbiter_pkg.sv
// Shared definitions for the 5-input round-robin mux arbiter:
// requester count, mux select encodings, FSM state codes and small helpers.
package mux5_arbiter_pkg;

    // Number of requesters sharing the mux output.
    localparam int N_REQ = 5;

    // Select codes understood by the 5-to-1 mux.
    // Index 4 maps to 101; codes 100, 110 and 111 are left unassigned in the mux.
    localparam logic [2:0] SEL_H0 = 3'b000;
    localparam logic [2:0] SEL_H1 = 3'b001;
    localparam logic [2:0] SEL_H2 = 3'b010;
    localparam logic [2:0] SEL_H3 = 3'b011;
    localparam logic [2:0] SEL_H4 = 3'b101;

    // Arbiter FSM states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Requester index -> mux select code. Out-of-range indices fall back to
    // input 0 so an illegal code can never reach the mux.
    function automatic logic [2:0] sel_enc(input logic [2:0] idx);
        logic [2:0] code;
        case (idx)
            3'd0:    code = SEL_H0;
            3'd1:    code = SEL_H1;
            3'd2:    code = SEL_H2;
            3'd3:    code = SEL_H3;
            3'd4:    code = SEL_H4;
            default: code = SEL_H0;
        endcase
        return code;
    endfunction

    // Requester index -> one-hot grant vector (zero for out-of-range indices).
    function automatic logic [N_REQ-1:0] onehot5(input logic [2:0] idx);
        logic [N_REQ-1:0] vec;
        vec = '0;
        if (idx < 3'(N_REQ)) begin
            vec[idx] = 1'b1;
        end
        return vec;
    endfunction

endpackage

// File: rtl/mux5_arbiter_if.sv
// Request/grant bundle between the datapath requesters and the mux arbiter.
//
// Handshake: req[i] is a level request, held high for as long as requester i
// wants the mux; it is not latched, so a request dropped before the arbiter
// samples it is simply never served. grant is the registered one-hot answer,
// s is the mux select that goes with it, and valid is high exactly while a
// grant is active (valid == |grant). en only gates new grants; a grant that
// is already running ends on its own (request drop or hold limit).
interface mux5_arbiter_if;
    import mux5_arbiter_pkg::*;

    logic             en;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [2:0]       s;
    logic             valid;

    // Requester / datapath side.
    modport master (
        output en,
        output req,
        input  grant,
        input  s,
        input  valid
    );

    // Arbiter side.
    modport slave (
        input  en,
        input  req,
        output grant,
        output s,
        output valid
    );

endinterface

// File: rtl/mux5_arbiter_rr_pick5.sv
// Combinational round-robin picker: finds the first set request bit scanning
// ptr, ptr+1, ... with wrap-around modulo 5.
module rr_pick5
    import mux5_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       ptr,
    output logic             any,
    output logic [2:0]       idx
);

    logic [2:0] pos;

    // Scan the five positions in priority order; the first hit wins.
    always_comb begin
        any = 1'b0;
        idx = 3'd0;
        pos = 3'd0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = 3'((32'(ptr) + 32'(k)) % 32'(N_REQ));
            if (!any && req[pos]) begin
                any = 1'b1;
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/mux5_arbiter.sv
// Round-robin arbiter for the shared 5-to-1 select mux. One requester holds
// the mux for at most MAX_HOLD cycles; every release is followed by one idle
// cycle before the next grant. The select output keeps its last code while
// idle so the mux never sees a glitch or an unassigned code.
module mux5_arbiter
    import mux5_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4
)(
    input  logic           clk,
    input  logic           rst_n,
    mux5_arbiter_if.slave  bus,
    output arb_state_e     state_dbg
);

    arb_state_e       state, state_nxt;
    logic [2:0]       ptr, ptr_nxt;
    logic [3:0]       hold_cnt, hold_nxt;
    logic [2:0]       gidx, gidx_nxt;
    logic [N_REQ-1:0] grant_q, grant_nxt;
    logic [2:0]       s_q, s_nxt;
    logic             valid_q, valid_nxt;

    logic             pick_any;
    logic [2:0]       pick_idx;
    logic             rel_now;

    rr_pick5 u_pick (
        .req (bus.req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // The granted requester gives up the mux when it drops its request or
    // has used its full hold budget; both at once is still one release.
    assign rel_now = !bus.req[gidx] || (hold_cnt == 4'(MAX_HOLD));

    // State, pointer, hold counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= 3'd0;
            hold_cnt <= 4'd0;
            gidx     <= 3'd0;
            grant_q  <= '0;
            s_q      <= SEL_H0;
            valid_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            gidx     <= gidx_nxt;
            grant_q  <= grant_nxt;
            s_q      <= s_nxt;
            valid_q  <= valid_nxt;
        end
    end

    // Next-state and next-output decision for the IDLE/BUSY FSM.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        gidx_nxt  = gidx;
        grant_nxt = grant_q;
        s_nxt     = s_q;
        valid_nxt = valid_q;
        case (state)
            ST_IDLE: begin
                // New grants only when enabled; otherwise outputs hold.
                if (bus.en && pick_any) begin
                    state_nxt = ST_BUSY;
                    gidx_nxt  = pick_idx;
                    grant_nxt = onehot5(pick_idx);
                    s_nxt     = sel_enc(pick_idx);
                    valid_nxt = 1'b1;
                    hold_nxt  = 4'd1;
                end
            end
            ST_BUSY: begin
                // en is deliberately ignored here: a running grant ends normally.
                if (rel_now) begin
                    state_nxt = ST_IDLE;
                    grant_nxt = '0;
                    valid_nxt = 1'b0;
                    hold_nxt  = 4'd0;
                    ptr_nxt   = (gidx == 3'd4) ? 3'd0 : gidx + 3'd1;
                    // s_nxt keeps the released requester's code.
                end else begin
                    hold_nxt = hold_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.grant = grant_q;
    assign bus.s     = s_q;
    assign bus.valid = valid_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_mux5_arbiter.sv
// Bench for mux5_arbiter: directed scenarios with literal expectations plus a
// long random run, all checked every cycle against a behavioural model.
module tb_mux5_arbiter;
    import mux5_arbiter_pkg::*;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst_n;
    arb_state_e state_dbg;
    logic       chk_on;

    int n_cmp;
    int n_err;

    mux5_arbiter_if bus_if ();

    mux5_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if.slave),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Who holds the mux, for how long, and where the rotation starts next.
    logic [2:0] enc_tab [5];
    int         m_busy;
    int         m_g;
    int         m_ptr;
    int         m_cnt;
    logic [2:0] m_s;

    initial begin
        enc_tab[0] = 3'b000;
        enc_tab[1] = 3'b001;
        enc_tab[2] = 3'b010;
        enc_tab[3] = 3'b011;
        enc_tab[4] = 3'b101;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0;
            m_g    = 0;
            m_ptr  = 0;
            m_cnt  = 0;
            m_s    = 3'b000;
        end else if (m_busy != 0) begin
            if (!bus_if.req[m_g] || m_cnt == MAX_HOLD) begin
                m_busy = 0;
                m_ptr  = (m_g + 1) % 5;
                m_cnt  = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end else if (bus_if.en && bus_if.req != 5'b0) begin
            for (int k = 0; k < 5; k++) begin
                if (m_busy == 0 && bus_if.req[(m_ptr + k) % 5]) begin
                    m_busy = 1;
                    m_g    = (m_ptr + k) % 5;
                end
            end
            m_cnt = 1;
            m_s   = enc_tab[m_g];
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            int exp_grant;
            exp_grant = (m_busy != 0) ? (1 << m_g) : 0;
            check("grant", int'(bus_if.grant), exp_grant);
            check("s", int'(bus_if.s), int'(m_s));
            check("valid", int'(bus_if.valid), m_busy);
            check("s_legal", int'(bus_if.s == 3'b100 || bus_if.s == 3'b110 || bus_if.s == 3'b111), 0);
            check("grant_onehot0", int'($onehot0(bus_if.grant)), 1);
            check("valid_eq_or_grant", int'(bus_if.valid), int'(|bus_if.grant));
        end
    end

    // ---------------- driver tasks ----------------
    // Asynchronous reset between edges; outputs must clear with no clock edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_rst_grant"}, int'(bus_if.grant), 0);
        check({tag, "_rst_s"}, int'(bus_if.s), 0);
        check({tag, "_rst_valid"}, int'(bus_if.valid), 0);
        check({tag, "_rst_state"}, int'(state_dbg), int'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int grant_idx(input logic [4:0] g);
        int r;
        r = -1;
        for (int i = 0; i < 5; i++) if (g[i]) r = i;
        return r;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [9:0] pat;
        logic       prev_v;
        int         order_q[$];
        logic [2:0] s_seq_q[$];
        logic [4:0] rq;

        n_cmp = 0;
        n_err = 0;
        chk_on = 1'b0;
        rst_n = 1'b0;
        bus_if.en = 1'b0;
        bus_if.req = 5'b0;
        #1;
        check("init_grant", int'(bus_if.grant), 0);
        check("init_valid", int'(bus_if.valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_on = 1'b1;

        // 1: reset in the middle of a grant, then first grant after reset.
        bus_if.en = 1'b1;
        bus_if.req = 5'b00100;
        @(negedge clk);
        check("t1_grant_before", int'(bus_if.grant), 5'b00100);
        async_reset("t1");
        @(negedge clk);
        check("t1_grant_after", int'(bus_if.grant), 5'b00100);
        check("t1_s_after", int'(bus_if.s), 3'b010);

        // 2: single persistent requester 4 -> 4 on, 1 off, repeating.
        bus_if.req = 5'b00000;
        async_reset("t2");
        bus_if.req = 5'b10000;
        pat = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            pat = {pat[8:0], bus_if.valid};
            if (c == 0) begin
                check("t2_s", int'(bus_if.s), 3'b101);
                check("t2_grant", int'(bus_if.grant), 5'b10000);
            end
        end
        check("t2_valid_pattern", int'(pat), 10'b1111011110);

        // 3: all requesting -> rotation 0,1,2,3,4,0 with matching selects.
        bus_if.req = 5'b00000;
        async_reset("t3");
        bus_if.req = 5'b11111;
        prev_v = 1'b0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (bus_if.valid && !prev_v) begin
                order_q.push_back(grant_idx(bus_if.grant));
                s_seq_q.push_back(bus_if.s);
            end
            prev_v = bus_if.valid;
        end
        check("t3_num_grants", (order_q.size() >= 6) ? 1 : 0, 1);
        if (order_q.size() >= 6) begin
            check("t3_order", order_q[0] * 100000 + order_q[1] * 10000 + order_q[2] * 1000 +
                  order_q[3] * 100 + order_q[4] * 10 + order_q[5], 1234 * 10 + 0);
            check("t3_s_seq", int'({s_seq_q[0], s_seq_q[1], s_seq_q[2], s_seq_q[3], s_seq_q[4], s_seq_q[5]}),
                  int'({3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b000}));
        end

        // 4: early release of requester 1, pointer moves to 2, requester 0 wins after wrap.
        bus_if.req = 5'b00000;
        async_reset("t4");
        bus_if.req = 5'b00010;
        @(negedge clk);
        check("t4_grant1", int'(bus_if.grant), 5'b00010);
        @(negedge clk);
        bus_if.req = 5'b00001;
        @(negedge clk);
        check("t4_released", int'(bus_if.valid), 0);
        check("t4_s_hold", int'(bus_if.s), 3'b001);
        @(negedge clk);
        check("t4_grant0", int'(bus_if.grant), 5'b00001);
        check("t4_s0", int'(bus_if.s), 3'b000);

        // 5: enable gating.
        bus_if.req = 5'b00000;
        async_reset("t5");
        bus_if.en = 1'b0;
        bus_if.req = 5'b01000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("t5_gated", int'(bus_if.valid), 0);
        end
        bus_if.en = 1'b1;
        @(negedge clk);
        check("t5_grant", int'(bus_if.grant), 5'b01000);
        check("t5_s", int'(bus_if.s), 3'b011);

        // 6: random requests/enable; the per-cycle compare does the checking.
        rq = 5'b0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            for (int b = 0; b < 5; b++) begin
                if ($urandom_range(0, 3) == 0) rq[b] = ~rq[b];
            end
            bus_if.req = rq;
            bus_if.en = ($urandom_range(0, 7) != 0);
        end
        @(negedge clk);
        @(negedge clk);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
